// File: rtl/ascii_uart_tx_pkg.sv
// Shared board-test definitions for the ASCII line transmitter.
package ascii_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam logic [7:0]  ASCII_CR   = 8'h0D;
    localparam logic [7:0]  ASCII_LF   = 8'h0A;
    localparam int unsigned LINE_BYTES = 10;

    // Line bytes 0..7 come from the shift register, then CR, then LF.
    function automatic logic [7:0] line_byte(input logic [3:0] idx, input logic [7:0] top);
        if (idx == 4'd8)      return ASCII_CR;
        else if (idx == 4'd9) return ASCII_LF;
        else                  return top;
    endfunction

endpackage

// File: rtl/ascii_uart_tx_byte.sv
// One 8N1 frame serializer; accepts the next byte in the last stop-bit cycle so frames abut.
module uart_tx_byte
    import ascii_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       tx,
    output logic       byte_ready
);

    localparam int unsigned      BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        data, data_n;
    logic              tx_n;
    logic              baud_last;

    assign baud_last  = (baud_cnt == BAUD_LAST);
    assign byte_ready = (state == ST_IDLE) || ((state == ST_STOP) && baud_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            data     <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            data     <= data_n;
            tx       <= tx_n;
        end
    end

    // tx_n is the line level for the cycle after the edge, keeping tx a pure register.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        data_n  = data;
        tx_n    = tx;
        if (state != ST_IDLE)
            baud_n = baud_last ? '0 : baud_cnt + BAUD_W'(1);
        case (state)
            ST_IDLE: tx_n = 1'b1;
            ST_START: begin
                if (baud_last) begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                    tx_n    = data[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n  = bit_cnt + 3'd1;
                        data_n = {1'b0, data[7:1]};
                        tx_n   = data[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    state_n = ST_IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (byte_ready && byte_valid) begin
            state_n = ST_START;
            baud_n  = '0;
            bit_n   = '0;
            data_n  = byte_data;
            tx_n    = 1'b0;
        end
    end

endmodule

// File: rtl/ascii_uart_tx.sv
// Sends an eight-character ASCII hex word followed by CR LF as one UART text line.
module ascii_uart_tx
    import ascii_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_BYTE = 4'(LINE_BYTES - 1);

    logic [63:0] shreg;
    logic [3:0]  idx, next_idx;
    logic        byte_valid, byte_ready;
    logic [7:0]  byte_data;
    logic        accept, advance;

    assign next_idx = idx + 4'd1;

    // Byte 0 bypasses the shift register so its start bit begins on the accept edge.
    always_comb begin
        accept     = 1'b0;
        advance    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = data_in[63:56];
        if (!busy) begin
            accept     = start;
            byte_valid = start;
        end else if (byte_ready && idx != LAST_BYTE) begin
            advance    = 1'b1;
            byte_valid = 1'b1;
            byte_data  = line_byte(next_idx, shreg[63:56]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                shreg <= {data_in[55:0], 8'h00};
                idx   <= '0;
                busy  <= 1'b1;
            end else if (advance) begin
                shreg <= {shreg[55:0], 8'h00};
                idx   <= next_idx;
            end else if (busy && byte_ready) begin
                idx  <= '0;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .tx         (tx),
        .byte_ready (byte_ready)
    );

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Randomized line-level bench for ascii_uart_tx with a per-cycle expected tx waveform.
module tb_ascii_uart_tx;

    localparam int unsigned CPB      = 4;
    localparam int unsigned LINE_CYC = 100 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] data_in;
    logic        tx, busy, done;

    int unsigned n_checks  = 0;
    int unsigned n_errors  = 0;
    int unsigned done_seen = 0;

    ascii_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line n-th bit (0..99): 10 frames of start, 8 data LSB first, stop.
    function automatic logic exp_bit(input logic [63:0] d, input int unsigned n);
        int unsigned b   = n / 10;
        int unsigned pos = n % 10;
        logic [7:0]  c;
        if (b < 8)       c = d[63 - 8*b -: 8];
        else if (b == 8) c = 8'h0D;
        else             c = 8'h0A;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return c[pos - 1];
    endfunction

    function automatic logic [63:0] rand_hex();
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            int unsigned v = $urandom_range(0, 15);
            r = {r[55:0], (v < 10) ? 8'(8'h30 + v) : 8'(8'h41 + v - 10)};
        end
        return r;
    endfunction

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_tx", 64'(tx), 64'd1);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_done", 64'(done), 64'd0);
            start   = 1'b0;
            data_in = {$urandom, $urandom};
        end
    endtask

    // Caller has start=1/data_in=d set for the coming edge; ends just after a negedge.
    task automatic run_line(input logic [63:0] d, input bit hold, input int unsigned poke_at,
                            input logic [63:0] poke_data, input int unsigned abort_at,
                            input logic [63:0] next_data);
        @(posedge clk);
        for (int unsigned j = 1; j <= LINE_CYC + 1; j++) begin
            @(negedge clk);
            if (abort_at != 0 && j == abort_at + 1) begin
                check("abort_tx", 64'(tx), 64'd1);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                rst   = 1'b0;
                start = 1'b0;
                return;
            end
            if (j <= LINE_CYC) begin
                check("line_tx", 64'(tx), 64'(exp_bit(d, (j - 1) / CPB)));
                check("line_busy", 64'(busy), 64'd1);
                check("line_done", 64'(done), 64'd0);
            end else begin
                check("end_done", 64'(done), 64'd1);
                check("end_busy", 64'(busy), 64'd0);
                check("end_tx", 64'(tx), 64'd1);
            end
            start   = hold;
            data_in = {$urandom, $urandom};
            if (j == poke_at) begin
                start   = 1'b1;
                data_in = poke_data;
            end
            if (j == abort_at) rst = 1'b1;
            if (j == LINE_CYC + 1) data_in = next_data;
        end
    endtask

    initial begin
        logic [63:0] a, b;
        rst     = 1'b1;
        start   = 1'b1;
        data_in = 64'h4445414442454546;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_tx", 64'(tx), 64'd1);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        idle(3);

        start = 1'b1; data_in = 64'h4445414442454546;
        run_line(64'h4445414442454546, 1'b0, 0, '0, 0, '0);
        idle(3);

        start = 1'b1; data_in = 64'h3030303030303030;
        run_line(64'h3030303030303030, 1'b0, 50, 64'h3131313131313131, 0, '0);
        idle(2);

        start = 1'b1; data_in = rand_hex();
        run_line(data_in, 1'b0, 0, '0, 37, '0);
        idle(4);
        start = 1'b1; data_in = rand_hex();
        run_line(data_in, 1'b0, 0, '0, 0, '0);
        idle(1);

        a = rand_hex();
        b = rand_hex();
        start = 1'b1; data_in = a;
        run_line(a, 1'b1, 0, '0, 0, b);
        run_line(b, 1'b0, 0, '0, 0, '0);
        idle(2);

        for (int n = 0; n < 5; n++) begin
            a = rand_hex();
            start = 1'b1; data_in = a;
            run_line(a, 1'b0, $urandom_range(1, LINE_CYC), rand_hex(), 0, '0);
            idle($urandom_range(1, 5));
        end

        check("done_count", 64'(done_seen), 64'd10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
